// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
// Contents: base opcode values, FSM state and op-class enums, and the
// encodings of the pc_sel / alu_a_sel / alu_b_sel / wb_sel / trap_cause outputs.
package rv_ctrl_pkg;

    // instr[6:0] of the legal RV32I base opcodes
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [3:0] {
        OpNone,
        OpLui,
        OpAuipc,
        OpJal,
        OpJalr,
        OpBranch,
        OpLoad,
        OpStore,
        OpImm,
        OpReg
    } op_class_e;

    // pc_sel
    localparam logic [1:0] PcSelPlus4 = 2'd0;
    localparam logic [1:0] PcSelImm   = 2'd1;
    localparam logic [1:0] PcSelJalr  = 2'd2;

    // alu_a_sel
    localparam logic [1:0] AluARs1  = 2'd0;
    localparam logic [1:0] AluAPc   = 2'd1;
    localparam logic [1:0] AluAZero = 2'd2;

    // alu_b_sel
    localparam logic AluBRs2 = 1'b0;
    localparam logic AluBImm = 1'b1;

    // wb_sel
    localparam logic [1:0] WbSelAlu = 2'd0;
    localparam logic [1:0] WbSelMem = 2'd1;
    localparam logic [1:0] WbSelPc4 = 2'd2;

    // trap_cause
    localparam logic [1:0] TrapNone    = 2'd0;
    localparam logic [1:0] TrapIllegal = 2'd1;
    localparam logic [1:0] TrapBus     = 2'd2;

endpackage

// File: rtl/rv_op_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i   - instr[6:0] from the instruction register
//   op_class_o - instruction class (OpNone when illegal)
//   legal_o    - 1 when opcode_i is one of the RV32I base opcodes
module rv_op_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  op_class_o,
    output logic       legal_o
);

    always_comb begin
        op_class_o = OpNone;
        legal_o    = 1'b1;
        case (opcode_i)
            OpcLui:    op_class_o = OpLui;
            OpcAuipc:  op_class_o = OpAuipc;
            OpcJal:    op_class_o = OpJal;
            OpcJalr:   op_class_o = OpJalr;
            OpcBranch: op_class_o = OpBranch;
            OpcLoad:   op_class_o = OpLoad;
            OpcStore:  op_class_o = OpStore;
            OpcOpImm:  op_class_o = OpImm;
            OpcOp:     op_class_o = OpReg;
            default:   legal_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control unit for an RV32I datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, drives datapath strobes
// and mux selects, handshakes with a variable-latency memory, traps on
// illegal opcodes and memory timeouts, and counts retired instructions.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   opcode              - instr[6:0] from the instruction register
//   branch_taken        - comparator result for the current branch
//   mem_ready           - memory accepts/returns data this cycle
//   mem_req, mem_we     - memory request and store/read qualifier
//   addr_sel            - memory address: 0 = PC, 1 = ALU result
//   ir_write, pc_write  - instruction register / PC load strobes
//   pc_sel              - next PC: PC+4, PC+imm, (rs1+imm)&~1
//   alu_a_sel/alu_b_sel - ALU operand selects
//   reg_write, wb_sel   - register-file write enable and source
//   trap, trap_cause    - sticky trap flag and its cause
//   retired             - instructions completed since reset (wraps)
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    op_class_e        op_class_q, op_class_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic [1:0]       trap_cause_q, trap_cause_d;

    op_class_e        dec_class;
    logic             dec_legal;
    logic             mem_busy;
    logic [WaitW-1:0] wait_inc;
    logic             timeout_hit;
    logic             retire;

    rv_op_decode u_op_decode (
        .opcode_i   (opcode),
        .op_class_o (dec_class),
        .legal_o    (dec_legal)
    );

    // States that hold a memory request open
    assign mem_busy = (state_q == StFetch) || (state_q == StMem);
    assign wait_inc = wait_q + WaitW'(1);
    // mem_ready in the limit cycle takes priority over the timeout
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_busy && !mem_ready &&
                         (wait_inc == WaitW'(MEM_TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            op_class_q   <= OpNone;
            wait_q       <= '0;
            retired_q    <= '0;
            trap_cause_q <= TrapNone;
        end else begin
            state_q      <= state_d;
            op_class_q   <= op_class_d;
            wait_q       <= wait_d;
            retired_q    <= retired_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        op_class_d   = op_class_q;
        trap_cause_d = trap_cause_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = TrapBus;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    op_class_d = dec_class;
                    state_d    = StExec;
                end else begin
                    op_class_d   = OpNone;
                    state_d      = StTrap;
                    trap_cause_d = TrapIllegal;
                end
            end
            StExec: begin
                case (op_class_q)
                    OpLoad, OpStore:          state_d = StMem;
                    OpJal, OpJalr, OpBranch:  state_d = StFetch;
                    OpLui, OpAuipc, OpImm, OpReg: state_d = StWb;
                    default:                  state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (op_class_q == OpStore) ? StFetch : StWb;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = TrapBus;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Wait counter and retire counter next-state
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
            wait_d = '0;
        end else if (mem_ready) begin
            wait_d = '0;
        end else if (mem_busy && (MEM_TIMEOUT != 0)) begin
            wait_d = wait_inc;
        end

        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    // Output decode: Moore on state_q/op_class_q, with same-cycle mem_ready and
    // branch_taken only on ir_write, pc_sel and completion strobes.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PcSelPlus4;
        alu_a_sel = AluARs1;
        alu_b_sel = AluBRs2;
        reg_write = 1'b0;
        wb_sel    = WbSelAlu;
        retire    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                StExec: begin
                    case (op_class_q)
                        OpReg: begin
                            alu_a_sel = AluARs1;
                            alu_b_sel = AluBRs2;
                        end
                        OpImm, OpLoad, OpStore: begin
                            alu_a_sel = AluARs1;
                            alu_b_sel = AluBImm;
                        end
                        OpLui: begin
                            alu_a_sel = AluAZero;
                            alu_b_sel = AluBImm;
                        end
                        OpAuipc: begin
                            alu_a_sel = AluAPc;
                            alu_b_sel = AluBImm;
                        end
                        OpJal, OpJalr: begin
                            reg_write = 1'b1;
                            wb_sel    = WbSelPc4;
                            pc_write  = 1'b1;
                            pc_sel    = (op_class_q == OpJal) ? PcSelImm : PcSelJalr;
                            retire    = 1'b1;
                        end
                        OpBranch: begin
                            pc_write = 1'b1;
                            pc_sel   = branch_taken ? PcSelImm : PcSelPlus4;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op_class_q == OpStore);
                    if ((op_class_q == OpStore) && mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                StWb: begin
                    reg_write = 1'b1;
                    wb_sel    = (op_class_q == OpLoad) ? WbSelMem : WbSelAlu;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap       = !rst && (state_q == StTrap);
    assign trap_cause = rst ? TrapNone : trap_cause_q;
    assign retired    = rst ? '0 : retired_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control unit for the RV32I datapath, replacing the single-cycle opcode decoder. A state machine sequences FETCH/DECODE/EXEC/MEM/WB per instruction, drives datapath strobes and mux selects, and handshakes with a variable-latency memory port. It adds features the single-cycle decoder lacks: illegal-opcode and memory-timeout traps, and a retired-instruction counter. It sits between the instruction register/comparator and the PC, register-file, ALU and memory muxes.

## Interface
- MEM_TIMEOUT, 16: cycles `mem_req` may wait for `mem_ready` before a bus trap; 0 disables the timeout.
- RET_W, 32: width of the retired-instruction counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- branch_taken  in  1  comparator result for the current branch.
- mem_ready  in  1  memory accepts/returns data this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store (1) / read (0); valid with mem_req.
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal opcode, 2 bus timeout.
- retired  out  RET_W  instructions completed since reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → FETCH.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other is illegal.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. Hold until mem_ready; in that cycle ir_write=1, → DECODE.
- DECODE: classify opcode into a registered op class. Illegal → TRAP with cause 1; otherwise → EXEC.
- EXEC by class:
  - OP: a=rs1, b=rs2 → WB.
  - OP-IMM/LOAD/STORE: a=rs1, b=imm. OP-IMM → WB; LOAD/STORE → MEM.
  - LUI: a=zero, b=imm → WB.
  - AUIPC: a=PC, b=imm → WB.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_sel=1, retire, → FETCH.
  - JALR: same, with pc_sel=2.
  - BRANCH: pc_write=1, pc_sel = branch_taken ? 1 : 0, retire, → FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=(STORE). Hold until mem_ready. Store: pc_write=1, pc_sel=0, retire, → FETCH. Load: → WB.
- WB: reg_write=1, wb_sel = LOAD ? 1 : 0, pc_write=1, pc_sel=0, retire, → FETCH.
- Retire means `retired` increments by 1 at the clock edge; it wraps at 2^RET_W.
- Timeout: the wait counter clears on entering FETCH/MEM and on mem_ready. It increments each cycle mem_req=1 and mem_ready=0. When it reaches MEM_TIMEOUT with no mem_ready in that cycle → TRAP, cause 2. mem_ready arriving in the same cycle as the limit wins (normal completion).
- TRAP: all strobes and mem_req are 0. trap=1 and trap_cause holds. State is held until rst.
- Outputs not listed for a state are 0.

## Timing
- While rst=1 and in the cycle after: state=FETCH, retired=0, trap=0, trap_cause=0, wait counter=0, op class=none. All strobes are 0 during rst; mem_req=1 from the first cycle with rst=0.
- Strobes are Moore outputs decoded from the state register plus the registered op class. No combinational path exists from mem_ready/branch_taken to state, except ir_write, pc_sel and completion strobes, which may depend on same-cycle mem_ready/branch_taken.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle): BRANCH/JAL/JALR 3 cycles, OP/OP-IMM/LUI/AUIPC/STORE 4, LOAD 5. Each memory wait cycle adds 1.
- rst asserted mid-instruction aborts it: no partial retire and no strobe in the reset cycle.

## Structure
- Package `rv_ctrl_pkg`: opcode localparams, state enum, op-class enum, and the pc_sel/alu_a_sel/wb_sel/trap_cause encodings.
- Sub-module `rv_op_decode`: combinational opcode → op class + legal flag, instantiated once and registered in DECODE.

## Test plan
- Reset, then an OP instruction (0110011) with mem_ready tied 1 → the FSM visits FETCH, DECODE, EXEC, WB; reg_write=1 and wb_sel=0 in cycle 4; retired=1.
- LOAD with mem_ready delayed 3 cycles in both FETCH and MEM → completes in 11 cycles; reg_write with wb_sel=1 in the last cycle.
- BRANCH with branch_taken=1, then with branch_taken=0 → pc_sel=1, then pc_sel=0; each takes 3 cycles with no reg_write.
- Opcode 1111111 → in the cycle after DECODE, trap=1 and trap_cause=1; no strobes for 10 more cycles; rst clears the trap.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH → trap_cause=2 after 4 wait cycles. Repeat with mem_ready=1 exactly at the limit cycle → no trap.
- RET_W=4: run 17 JAL instructions → retired wraps to 1. Assert rst during the MEM state of a STORE → no mem_we after the reset edge, and retired=0.
